// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: operand/product widths and the multiplier FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Imported by the multiplier, its interface and regC.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Control-unit <-> multiplier bundle: start/operands in, product/loadC/busy out.
// Latency: n/a (wires only).
// Backpressure: the control unit (master) must hold off start while busy is high; starts seen while busy are dropped.
// Ports: start, opA, opB (master -> slave); product, loadC, busy (slave -> master).
interface mult_seq_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic                 start;
  logic [WIDTH-1:0]     opA;
  logic [WIDTH-1:0]     opB;
  logic [2*WIDTH-1:0]   product;
  logic                 loadC;
  logic                 busy;

  modport master (
    output start, opA, opB,
    input  product, loadC, busy
  );

  modport slave (
    input  start, opA, opB,
    output product, loadC, busy
  );

endinterface

// File: rtl/mult_step.sv
// One multiply iteration: conditional add (or Booth add/sub) of the multiplicand into the high half, then a 1-bit right shift.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
// Ports: i_acc/i_mcand in, o_acc out; with MULT_SIGNED_EN defined also i_q/o_q (Booth q-1 bit).
module mult_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
`ifdef MULT_SIGNED_EN
  input  logic               i_q,
  output logic               o_q,
`endif
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  // One extra bit so the carry (unsigned) or the true sign (Booth) survives the add.
  logic [WIDTH:0]   w_sum;

  assign w_hi = i_acc[2*WIDTH-1:WIDTH];
  assign w_lo = i_acc[WIDTH-1:0];

`ifdef MULT_SIGNED_EN
  logic [WIDTH:0] w_hi_x;
  logic [WIDTH:0] w_mc_x;

  assign w_hi_x = {w_hi[WIDTH-1], w_hi};
  assign w_mc_x = {i_mcand[WIDTH-1], i_mcand};

  always_comb begin
    w_sum = w_hi_x;
    case ({w_lo[0], i_q})
      2'b01:   w_sum = w_hi_x + w_mc_x;
      2'b10:   w_sum = w_hi_x - w_mc_x;
      default: w_sum = w_hi_x;
    endcase
  end

  assign o_q = w_lo[0];
`else
  always_comb begin
    w_sum = {1'b0, w_hi};
    if (w_lo[0]) begin
      w_sum = {1'b0, w_hi} + {1'b0, i_mcand};
    end
  end
`endif

  // {sum, lo} >> 1 keeping 2*WIDTH bits. sum[WIDTH] becomes the new MSB:
  // the carry when unsigned, the sign bit (arithmetic shift) under Booth.
  assign o_acc = {w_sum, w_lo[WIDTH-1:1]};

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier feeding regC (product -> dataCin, loadC -> loadC); radix-2 Booth signed when MULT_SIGNED_EN is defined.
// Latency: WIDTH+1 edges from the accepting edge to the edge that raises loadC; starts may be spaced WIDTH+2 cycles apart.
// Backpressure: busy is high from accept until the result edge; start while busy is ignored, not queued.
// Ports: clk, rst (async active-high); bus (mult_seq_if.slave): start, opA, opB in; product, loadC, busy out.
module mult_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic           clk,
  input logic           rst,
  mult_seq_if.slave     bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_loadC;
  logic                 r_busy;
  logic [2*WIDTH-1:0]   w_acc_next;

`ifdef MULT_SIGNED_EN
  logic                 r_q;
  logic                 w_q_next;
`endif

  mult_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
`ifdef MULT_SIGNED_EN
    .i_q     (r_q),
    .o_q     (w_q_next),
`endif
    .o_acc   (w_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_loadC   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef MULT_SIGNED_EN
      r_q       <= 1'b0;
`endif
    end else begin
      r_loadC <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mcand <= bus.opA;
            r_acc   <= {{WIDTH{1'b0}}, bus.opB};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef MULT_SIGNED_EN
            r_q     <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CNT_W'(1);
`ifdef MULT_SIGNED_EN
          r_q     <= w_q_next;
`endif
          // This edge performs the last of the WIDTH iterations.
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // product only moves here, so regC always samples a stable value.
          r_product <= r_acc;
          r_loadC   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.loadC   = r_loadC;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq with a scoreboard queue and a behavioural regC.
// Latency: checks WIDTH+1 edges from accept to loadC.
// Backpressure: exercises starts issued while busy (must be dropped) and a start in the loadC cycle (must be taken).
module tb_mult_seq;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(DATA_W)) bus ();

  mult_seq #(.WIDTH(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                 n_checks = 0;
  int                 n_fail   = 0;
  int                 n_loadc  = 0;
  logic [PROD_W-1:0]  exp_q[$];
  logic [PROD_W-1:0]  regc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [PROD_W-1:0] model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] sp;
`ifdef MULT_SIGNED_EN
    sp = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
`else
    sp = $signed({{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b});
`endif
    return sp;
  endfunction

  // Behavioural regC: loads dataCin on loadC.
  always @(posedge clk or posedge rst) begin
    if (rst) regc <= '0;
    else if (bus.loadC) regc <= bus.product;
  end

  // Scoreboard consumer: every loadC must match the oldest outstanding request.
  always @(posedge clk) begin
    #1;
    if (bus.loadC === 1'b1) begin
      n_loadc++;
      if (exp_q.size() == 0) chk("unexpected_loadC", 64'd1, 64'd0);
      else chk("product", bus.product, exp_q.pop_front());
    end
  end

  // Drive start for one cycle; returns at the negedge just after the accepting edge.
  task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for loadC; returns edge count since the accepting edge, 0 on timeout.
  task automatic wait_loadc(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.loadC === 1'b1) begin
        found = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int n;
    logic [PROD_W-1:0] e;
    e = model(a, b);
    start_op(a, b, 1'b1);
    chk("busy_run", bus.busy, 64'd1);
    wait_loadc(n);
    chk("latency", n, 64'd17);
    @(posedge clk);
    #1;
    chk("busy_after", bus.busy, 64'd0);
    chk("regc_load", regc, e);
    repeat (3) @(posedge clk);
    #1;
    chk("regc_hold", regc, e);
    chk("product_hold", bus.product, e);
  endtask

  logic [DATA_W-1:0] pat_a[7] = '{16'h0003, 16'hFFFF, 16'h1234, 16'hFFFD, 16'h8000, 16'h7FFF, 16'h0000};
  logic [DATA_W-1:0] pat_b[7] = '{16'h0005, 16'hFFFF, 16'h0FE6, 16'h0005, 16'h8000, 16'h8000, 16'h1234};

  initial begin
    int n;
    int n0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    repeat (2) @(negedge clk);
    chk("rst_product", bus.product, 64'd0);
    chk("rst_loadC", bus.loadC, 64'd0);
    chk("rst_busy", bus.busy, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op(pat_a[i], pat_b[i]);
    for (int i = 0; i < 4; i++) run_op(DATA_W'($urandom), DATA_W'($urandom));

    // Starts during RUN and DONE are dropped; a start in the loadC cycle is taken.
    n0 = n_loadc;
    start_op(16'h0011, 16'h0022, 1'b1);         // between edges 0 and 1
    repeat (4) @(negedge clk);                  // between edges 4 and 5
    bus.start = 1'b1; bus.opA = 16'hAAAA; bus.opB = 16'hBBBB;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);                 // between edges 16 and 17: DONE
    chk("busy_done", bus.busy, 64'd1);
    bus.start = 1'b1; bus.opA = 16'h0F0F; bus.opB = 16'h0F0F;
    @(negedge clk);                             // loadC cycle
    chk("loadC_first", bus.loadC, 64'd1);
    bus.opA = 16'h0009; bus.opB = 16'h0009;
    exp_q.push_back(model(16'h0009, 16'h0009));
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_reaccept", bus.busy, 64'd1);
    wait_loadc(n);
    chk("latency_reaccept", n, 64'd17);
    @(negedge clk);
    chk("loadc_count", n_loadc - n0, 64'd2);

    // Reset mid-operation discards the in-flight result.
    start_op(16'h0055, 16'h0066, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_product", bus.product, 64'd0);
    chk("midrst_loadC", bus.loadC, 64'd0);
    chk("midrst_busy", bus.busy, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0002, 16'h0007);

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
